// File: rtl/risc16_pkg.sv
// Shared RiSC-16 definitions: field widths, opcodes, the halt encoding and the
// per-class PC stall counts.
package risc16_pkg;
  localparam int ADDR_W  = 6;
  localparam int INSTR_W = 16;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_ADDI = 3'b001,
    OP_NAND = 3'b010,
    OP_LUI  = 3'b011,
    OP_SW   = 3'b100,
    OP_LW   = 3'b101,
    OP_BEQ  = 3'b110,
    OP_JALR = 3'b111
  } opcode_e;

  localparam logic [INSTR_W-1:0] HALT_INSTR = 16'hE071;

  localparam logic [1:0] WAIT_ALU   = 2'd1;
  localparam logic [1:0] WAIT_CTRL  = 2'd2;
  localparam logic [1:0] WAIT_MEM   = 2'd3;
  localparam logic [1:0] WAIT_FETCH = 2'd3;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic [1:0]        wait_class;
    logic              is_beq;
    logic              is_jalr;
    logic              is_halt;
    logic [ADDR_W-1:0] beq_offset;
  } instr_class_t;
endpackage

// File: rtl/instr_class_decoder.sv
// Classifies a fetched word into its stall class and control-flow kind.
// The beq offset is sign-extended and kept at address width, since PC math wraps mod 64.
module instr_class_decoder
  import risc16_pkg::*;
(
  input  logic [INSTR_W-1:0] rom_data,
  output instr_class_t       cls
);
  opcode_e op;
  logic [INSTR_W-1:0] sext_imm;

  assign op       = opcode_e'(rom_data[15:13]);
  assign sext_imm = {{(INSTR_W-7){rom_data[6]}}, rom_data[6:0]};

  always_comb begin
    cls            = '0;
    cls.wait_class = WAIT_ALU;
    cls.beq_offset = sext_imm[ADDR_W-1:0];
    cls.is_halt    = (rom_data == HALT_INSTR);
    unique case (op)
      OP_ADD, OP_ADDI, OP_NAND, OP_LUI: cls.wait_class = WAIT_ALU;
      OP_SW, OP_LW:                     cls.wait_class = WAIT_MEM;
      OP_BEQ: begin
        cls.wait_class = WAIT_CTRL;
        cls.is_beq     = 1'b1;
      end
      OP_JALR: begin
        cls.wait_class = WAIT_CTRL;
        cls.is_jalr    = 1'b1;
      end
      default: cls.wait_class = WAIT_ALU;
    endcase
  end
endmodule

// File: rtl/fetch_sequencer.sv
// Sequences the RiSC-16 program counter: fetches at PC, picks the stall count
// and next address, and parks the machine once the halt instruction retires.
module fetch_sequencer
  import risc16_pkg::*;
(
  input  logic               clk0,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_addr,
  output logic [ADDR_W-1:0]  next_address,
  output logic [1:0]         wait_cycle,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               beq_equal,
  input  logic [INSTR_W-1:0] jalr_target,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [1:0]         phase,
  output logic               retire,
  output logic               halted
);
  seq_state_e        state_q, state_d;
  logic [1:0]        phase_q;
  logic [ADDR_W-1:0] pc_plus_one_q;
  instr_class_t      cls;
  logic              run;
  logic              decode;

  instr_class_decoder u_dec (
    .rom_data (rom_data),
    .cls      (cls)
  );

  assign run      = (state_q == ST_RUN);
  assign decode   = run && (phase_q != 2'd0);
  assign rom_addr = pc_addr;

  // Phase 0 always asks for 3 so the PC cannot load before rom_data is valid.
  always_comb begin
    wait_cycle   = WAIT_FETCH;
    next_address = pc_addr;
    state_d      = state_q;
    if (decode) begin
      wait_cycle = cls.wait_class;
      if (cls.is_halt)
        next_address = pc_addr;
      else if (cls.is_beq)
        next_address = beq_equal ? pc_plus_one_q + cls.beq_offset : pc_plus_one_q;
      else if (cls.is_jalr)
        next_address = jalr_target[ADDR_W-1:0];
      else
        next_address = pc_plus_one_q;
    end
    retire = run && (phase_q == wait_cycle);
    if (retire && cls.is_halt)
      state_d = ST_HALT;
  end

  // phase mirrors the PC's own counter, so it keeps running while halted.
  always_ff @(posedge clk0) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      phase_q       <= 2'd0;
      pc_plus_one_q <= ADDR_W'(1);
    end else begin
      state_q <= state_d;
      phase_q <= (phase_q == wait_cycle) ? 2'd0 : phase_q + 2'd1;
      if (phase_q == 2'd0)
        pc_plus_one_q <= pc_addr + ADDR_W'(1);
    end
  end

  assign phase       = phase_q;
  assign instr_valid = decode;
  assign instr       = decode ? rom_data : '0;
  assign halted      = (state_q == ST_HALT);
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: models the program counter and synchronous ROM,
// and checks every retired instruction against an ISA-level next-PC/period model.
module tb_fetch_sequencer;
  logic        clk0;
  logic        reset;
  logic [5:0]  pc_addr;
  logic [5:0]  next_address;
  logic [1:0]  wait_cycle;
  logic [5:0]  rom_addr;
  logic [15:0] rom_data;
  logic        beq_equal;
  logic [15:0] jalr_target;
  logic [15:0] instr;
  logic        instr_valid;
  logic [1:0]  phase;
  logic        retire;
  logic        halted;

  logic [15:0] rom [64];
  logic [1:0]  cnt;
  int          n_checks = 0;
  int          n_pass   = 0;

  fetch_sequencer dut (
    .clk0         (clk0),
    .reset        (reset),
    .pc_addr      (pc_addr),
    .next_address (next_address),
    .wait_cycle   (wait_cycle),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .beq_equal    (beq_equal),
    .jalr_target  (jalr_target),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .phase        (phase),
    .retire       (retire),
    .halted       (halted)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  // Program counter as it behaves on the board: counter, compare, load.
  always @(posedge clk0) begin
    if (!reset) begin
      pc_addr <= 6'd0;
      cnt     <= 2'd0;
    end else if (cnt == wait_cycle) begin
      cnt     <= 2'd0;
      pc_addr <= next_address;
    end else begin
      cnt <= cnt + 2'd1;
    end
  end

  always @(posedge clk0) rom_data <= rom[rom_addr];

  task automatic tick;
    @(posedge clk0);
    #1;
  endtask

  function automatic logic [5:0] model_next(input logic [5:0] p, input logic [15:0] ins,
                                            input logic eq, input logic [15:0] jt);
    int s, t;
    if (ins == 16'hE071) return p;
    case (ins[15:13])
      3'd6: begin
        s = ins[6] ? int'(ins[6:0]) - 128 : int'(ins[6:0]);
        t = eq ? (int'(p) + 1 + s) : (int'(p) + 1);
        return 6'(((t % 64) + 64) % 64);
      end
      3'd7:    return jt[5:0];
      default: return 6'((int'(p) + 1) % 64);
    endcase
  endfunction

  function automatic int model_period(input logic [15:0] ins);
    case (ins[15:13])
      3'd0, 3'd1, 3'd2, 3'd3: return 2;
      3'd4, 3'd5:             return 4;
      default:                return 3;
    endcase
  endfunction

  // Runs one instruction from its phase-0 cycle through the PC load edge.
  task automatic run_instr(input logic eq, input logic [15:0] jt);
    logic [5:0]  p, exp;
    logic [15:0] ins;
    int          per, cyc;
    bit          got;
    p = pc_addr; ins = rom[p];
    exp = model_next(p, ins, eq, jt);
    per = model_period(ins);
    beq_equal = eq; jalr_target = jt;
    n_checks++; if (phase !== 2'd0) $display("FAIL fetch_phase pc=%0d got %0d want 0", p, phase); else n_pass++;
    n_checks++; if (wait_cycle !== 2'd3) $display("FAIL fetch_wait pc=%0d got %0d want 3", p, wait_cycle); else n_pass++;
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL fetch_valid pc=%0d got %b want 0", p, instr_valid); else n_pass++;
    cyc = 1; got = 0;
    for (int k = 0; k < 6 && !got; k++) begin
      tick; cyc++;
      if (cyc == 2) begin
        n_checks++; if (instr !== ins) $display("FAIL instr pc=%0d got %h want %h", p, instr, ins); else n_pass++;
        n_checks++; if (wait_cycle !== 2'(per - 1)) $display("FAIL wait_cycle pc=%0d got %0d want %0d", p, wait_cycle, per - 1); else n_pass++;
      end
      if (retire === 1'b1) got = 1;
    end
    n_checks++; if (!got) $display("FAIL retire_timeout pc=%0d ins=%h", p, ins); else n_pass++;
    n_checks++; if (cyc != per) $display("FAIL period pc=%0d ins=%h got %0d want %0d", p, ins, cyc, per); else n_pass++;
    n_checks++; if (next_address !== exp) $display("FAIL next_address pc=%0d ins=%h got %0d want %0d", p, ins, next_address, exp); else n_pass++;
    tick;
    n_checks++; if (pc_addr !== exp) $display("FAIL pc_load pc=%0d got %0d want %0d", p, pc_addr, exp); else n_pass++;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    tick;
    reset = 1'b1;
  endtask

  // Reset, then a jalr at PC 0 lands the PC on addr (upper target bits ignored).
  task automatic goto(input logic [5:0] addr);
    do_reset;
    rom[0] = 16'hE000;
    run_instr(1'b0, {10'h3FF, addr});
  endtask

  task automatic test_reset;
    reset = 1'b0; beq_equal = 1'b0; jalr_target = '0;
    tick; tick;
    n_checks++; if (phase !== 2'd0) $display("FAIL rst_phase got %0d want 0", phase); else n_pass++;
    n_checks++; if (wait_cycle !== 2'd3) $display("FAIL rst_wait got %0d want 3", wait_cycle); else n_pass++;
    n_checks++; if (next_address !== 6'd0) $display("FAIL rst_next got %0d want 0", next_address); else n_pass++;
    n_checks++; if (rom_addr !== 6'd0) $display("FAIL rst_rom_addr got %0d want 0", rom_addr); else n_pass++;
    n_checks++; if (instr !== 16'd0) $display("FAIL rst_instr got %h want 0", instr); else n_pass++;
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", instr_valid); else n_pass++;
    n_checks++; if (retire !== 1'b0) $display("FAIL rst_retire got %b want 0", retire); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("FAIL rst_halted got %b want 0", halted); else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_first_add;
    rom[0] = 16'h0000;
    rom[1] = 16'h2000;
    do_reset;
    run_instr(1'b0, 16'h0);
    run_instr(1'b0, 16'h0);
  endtask

  task automatic test_lw;
    rom[5] = 16'hA000;
    goto(6'd5);
    run_instr(1'b0, 16'h0);
  endtask

  task automatic test_beq;
    rom[10] = 16'hC07D;
    goto(6'd10);
    run_instr(1'b1, 16'h0);
    goto(6'd10);
    run_instr(1'b0, 16'h0);
  endtask

  task automatic test_jalr_wrap;
    do_reset;
    rom[0] = 16'hE000;
    run_instr(1'b0, 16'h0123);
    rom[63] = 16'h0000;
    goto(6'd63);
    run_instr(1'b0, 16'h0);
  endtask

  task automatic test_halt;
    int bad_v, bad_r, bad_pc, bad_h, bad_ph;
    rom[4] = 16'hE071;
    goto(6'd4);
    run_instr(1'b0, 16'h0);
    bad_v = 0; bad_r = 0; bad_pc = 0; bad_h = 0; bad_ph = 0;
    for (int k = 0; k < 20; k++) begin
      if (instr_valid !== 1'b0) bad_v++;
      if (retire !== 1'b0) bad_r++;
      if (pc_addr !== 6'd4) bad_pc++;
      if (halted !== 1'b1) bad_h++;
      if (phase !== cnt) bad_ph++;
      tick;
    end
    n_checks++; if (bad_h != 0) $display("FAIL halt_halted bad cycles %0d want 0", bad_h); else n_pass++;
    n_checks++; if (bad_v != 0) $display("FAIL halt_valid bad cycles %0d want 0", bad_v); else n_pass++;
    n_checks++; if (bad_r != 0) $display("FAIL halt_retire bad cycles %0d want 0", bad_r); else n_pass++;
    n_checks++; if (bad_pc != 0) $display("FAIL halt_pc bad cycles %0d want 0", bad_pc); else n_pass++;
    n_checks++; if (bad_ph != 0) $display("FAIL halt_phase_track bad cycles %0d want 0", bad_ph); else n_pass++;
    do_reset;
    n_checks++; if (pc_addr !== 6'd0) $display("FAIL halt_rst_pc got %0d want 0", pc_addr); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("FAIL halt_rst_halted got %b want 0", halted); else n_pass++;
  endtask

  task automatic test_reset_mid_sw;
    rom[2] = 16'h8000;
    goto(6'd2);
    tick; tick;
    n_checks++; if (phase !== 2'd2) $display("FAIL sw_phase got %0d want 2", phase); else n_pass++;
    do_reset;
    n_checks++; if (phase !== 2'd0) $display("FAIL sw_rst_phase got %0d want 0", phase); else n_pass++;
    n_checks++; if (pc_addr !== 6'd0) $display("FAIL sw_rst_pc got %0d want 0", pc_addr); else n_pass++;
    run_instr(1'b0, 16'h0011);
  endtask

  task automatic test_random;
    for (int i = 0; i < 64; i++) begin
      rom[i] = 16'($urandom);
      if (rom[i] == 16'hE071) rom[i] = 16'hE070;
    end
    do_reset;
    for (int n = 0; n < 200; n++)
      run_instr(1'($urandom), 16'($urandom));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
    rom_data = 16'h0000;
    reset = 1'b0;
    test_reset;
    test_first_add;
    test_lw;
    test_beq;
    test_jalr_wrap;
    test_halt;
    test_reset_mid_sw;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Drives the RiSC-16 FPGA program counter and fetches the instruction it points to. Each cycle it supplies the next address and the per-instruction stall count (`wait_cycle`) to the program counter. It reads the 16-bit instruction from a synchronous instruction ROM at the current PC, presents it to decode, and resolves sequential, `beq` and `jalr` next addresses. It also detects the halt instruction.

## Interface
- No parameters. Widths are fixed: address 6 bits, instruction 16 bits.
- `clk0  in  1`  system clock; all state updates on the rising edge.
- `reset  in  1`  synchronous, active-low reset.
- `pc_addr  in  6`  current PC, from the program counter's `address_out`.
- `next_address  out  6`  to the program counter's `address_in`.
- `wait_cycle  out  2`  to the program counter's `wait_cycle`.
- `rom_addr  out  6`  instruction ROM address, equal to `pc_addr`.
- `rom_data  in  16`  ROM read data, valid one cycle after `rom_addr` changes.
- `beq_equal  in  1`  datapath register compare result for the current `beq`.
- `jalr_target  in  16`  regB value for the current `jalr`; only bits [5:0] are used.
- `instr  out  16`  current instruction, equal to `rom_data` gated by `instr_valid`, else 0.
- `instr_valid  out  1`  `instr` is valid for decode.
- `phase  out  2`  shadow of the program counter's internal counter.
- `retire  out  1`  the program counter loads `next_address` at the coming edge.
- `halted  out  1`  sticky; set after the halt instruction retires.

## Operation
- Shadow counter `phase` mirrors the program counter's counter.
  - Reset to 0.
  - If `phase != wait_cycle`: increment.
  - Else: return to 0. This is the PC load edge.
- `retire = (phase == wait_cycle)` combinationally, and 0 while `halted`.
- Phase 0 is the fetch cycle. `rom_data` is not yet valid.
  - Drive `wait_cycle = 3`. This guarantees no PC load at the end of phase 0.
  - Register `pc_plus_one = pc_addr + 1` (mod 64; 63 wraps to 0).
- Phase ≥ 1: classify `rom_data` (opcode = bits [15:13]).
  - 000 add, 001 addi, 010 nand, 011 lui: `wait_cycle = 1` (2-cycle instruction).
  - 110 beq, 111 jalr: `wait_cycle = 2` (3 cycles).
  - 100 sw, 101 lw: `wait_cycle = 3` (4 cycles).
- `next_address` in phase ≥ 1:
  - `beq` with `beq_equal = 1`: `pc_plus_one + sext(rom_data[6:0])`, truncated to 6 bits.
  - `beq` with `beq_equal = 0`: `pc_plus_one`.
  - `jalr`: `jalr_target[5:0]`.
  - Halt (`rom_data == 16'hE071`): `pc_addr`.
  - All others: `pc_plus_one`.
- `next_address` in phase 0: `pc_addr`. It is don't-care to the program counter, but is held to this value.
- `beq_equal` and `jalr_target` are sampled only at the retire edge. The datapath must hold them stable from phase 1 until retire.
- State machine RUN/HALT:
  - RUN → HALT at the retire edge of the halt instruction.
  - HALT → RUN only by reset.
  - In HALT: `wait_cycle = 3`, `next_address = pc_addr`, `instr_valid = 0`, `halted = 1`. The PC reloads its own value every 4 cycles, and `phase` keeps tracking it.
- `instr_valid = (phase != 0) && RUN`.

## Timing
- Reset values:
  - `phase = 0`, state RUN, `pc_plus_one = 1`.
  - `wait_cycle = 3`, `next_address = 0`, `rom_addr = 0`.
  - `instr = 0`, `instr_valid = 0`, `retire = 0`, `halted = 0`.
- Reset mid-instruction: all state returns to reset values at the same edge that resets the program counter, so the two stay aligned. No partial instruction survives.
- Fetch latency is 1 cycle: instruction valid in phase 1.
- Instruction period is `wait_cycle + 1`, giving 2, 3 or 4 cycles.
- `wait_cycle` may change between phase 0 and phase 1. It is always ≥ `phase`, so the program counter never misses its compare.
- `rom_addr` is combinational from `pc_addr`.
- `wait_cycle`, `next_address` and `retire` are combinational from `phase`, `rom_data` and inputs. `phase`, `pc_plus_one` and the state are registered.

## Structure
- Shared package `risc16_pkg`:
  - Opcode constants.
  - `HALT_INSTR = 16'hE071`.
  - Wait-class constants `WAIT_ALU = 1`, `WAIT_CTRL = 2`, `WAIT_MEM = 3`, `WAIT_FETCH = 3`.
  - `ADDR_W = 6`, `INSTR_W = 16`.
- One sub-module `instr_class_decoder`: combinational from `rom_data` to `wait_class`, `is_beq`, `is_jalr`, `is_halt`, and the sign-extended `beq` offset.

## Test plan
- Reset release, ROM[0] = add:
  - Phase 0: `wait_cycle = 3`, `instr_valid = 0`.
  - Phase 1: `wait_cycle = 1`, `retire = 1`, `next_address = 1`.
  - PC reads 1 two cycles after reset release.
- `lw` at PC 5: `phase` runs 0,1,2,3; `retire` only in phase 3; `next_address = 6`; PC becomes 6 after 4 cycles.
- `beq` at PC 10 with imm7 = 7'h7D (−3):
  - `beq_equal = 1`: PC becomes 8.
  - `beq_equal = 0`: PC becomes 11.
  - Each takes 3 cycles.
- `jalr` with `jalr_target = 16'h0123`: PC becomes 6'h23. Separately, `add` at PC 63: PC wraps to 0.
- Halt at PC 4:
  - `halted` rises after its retire edge; PC stays 4; `instr_valid` stays 0 and `retire` stays 0 for 20 cycles.
  - Then reset low for 1 cycle: PC 0, `halted = 0`.
- Reset asserted during phase 2 of an `sw`: next cycle `phase = 0` and PC = 0, then normal fetch of ROM[0].
